// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: byte-wide valid/ready write port of the buffered UART transmitter
interface uart_tx_fifo_if;
    logic [7:0] data;
    logic       data_valid;
    logic       ready;
    modport master (output data, output data_valid, input ready);
    modport slave (input data, input data_valid, output ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1/8N2 UART transmitter, LSB first, line idles high
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_tx_fifo_if.slave               bus,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int BIT_CLKS = CLK_FREQ / BAUD_RATE;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BIT_CLKS);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [3:0]    bit_idx, bit_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [7:0]    shift_reg;
    logic          push, pop, baud_done, last_stop, tx_d;
    assign bus.ready = fifo_count != (AW+1)'(FIFO_DEPTH);
    assign push      = bus.data_valid && bus.ready;
    assign baud_done = baud == BW'(BIT_CLKS - 1);
    assign last_stop = state == STOP && baud_done && bit_idx == 4'(STOP_BITS - 1);
    assign pop       = fifo_count != '0 && (state == IDLE || last_stop);
    assign busy      = state != IDLE || fifo_count != '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            wp         <= '0;
            rp         <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= bus.data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud      <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_n;
            tx      <= tx_d;
            if (pop) shift_reg <= mem[rp];
        end
    end
    // bit_idx counts data bits in DATA and stop bits in STOP
    always_comb begin
        state_n = state;
        bit_n   = bit_idx;
        baud_n  = (state == IDLE || baud_done) ? '0 : baud + 1'b1;
        case (state)
            IDLE:  state_n = pop ? START : IDLE;
            START: if (baud_done) begin
                state_n = DATA;
                bit_n   = '0;
            end
            DATA:  if (baud_done) begin
                state_n = bit_idx == 4'd7 ? STOP : DATA;
                bit_n   = bit_idx == 4'd7 ? '0 : bit_idx + 1'b1;
            end
            STOP:  if (baud_done) begin
                state_n = last_stop ? (pop ? START : IDLE) : STOP;
                bit_n   = last_stop ? '0 : bit_idx + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
    always_comb tx_d = state_n == START ? 1'b0 : state_n == DATA ? shift_reg[bit_n[2:0]] : 1'b1;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and random checks of uart_tx_fifo against frame-level expectations
module tb_uart_tx_fifo;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;
    uart_tx_fifo_if i1 (), i2 ();
    logic tx1, tx2, busy1, busy2;
    logic [2:0] cnt1, cnt2;
    uart_tx_fifo #(.CLK_FREQ(16), .BAUD_RATE(1), .FIFO_DEPTH(4), .STOP_BITS(1)) d1 (
        .clk(clk), .rst(rst), .bus(i1), .tx(tx1), .busy(busy1), .fifo_count(cnt1));
    uart_tx_fifo #(.CLK_FREQ(16), .BAUD_RATE(1), .FIFO_DEPTH(4), .STOP_BITS(2)) d2 (
        .clk(clk), .rst(rst), .bus(i2), .tx(tx2), .busy(busy2), .fifo_count(cnt2));
    int vec = 0, errs = 0, cyc = 0, rule_bad = 0, full_seen = 0, idle_bad = 0, rx_ferr = 0;
    logic [7:0] pend1[$], pend2[$], rxq[$];
    int acc1[$], fst[$];
    logic r1 = 0, r2 = 0;
    logic rx_en = 0, rx_on = 0, prev = 1;
    int rx_t = 0;
    logic [7:0] rx_b;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // one clock: retire accepted bytes, then offer the next queued byte on each port
    task automatic step();
        @(negedge clk);
        cyc++;
        if (i1.data_valid && r1) begin
            void'(pend1.pop_front());
            acc1.push_back(cyc);
        end
        if (i2.data_valid && r2) void'(pend2.pop_front());
        if (i1.ready !== (cnt1 != 3'd4)) rule_bad++;
        if (cnt1 == 3'd4 && !i1.ready) full_seen++;
        i1.data_valid = pend1.size() != 0;
        i1.data = 8'h00;
        if (pend1.size() != 0) i1.data = pend1[0];
        i2.data_valid = pend2.size() != 0;
        i2.data = 8'h00;
        if (pend2.size() != 0) i2.data = pend2[0];
        r1 = i1.ready;
        r2 = i2.ready;
    endtask
    // expected line: bit slot 0 is start, 1..8 data LSB first, rest stop
    task automatic check_frame(input int w, input logic [7:0] b, input int sb, input int n);
        int lim;
        lim = n != 0 ? n : (9 + sb) * 16;
        for (int k = 0; k < lim; k++) begin
            int bi;
            logic e;
            step();
            if (k == 0) fst.push_back(cyc);
            bi = k / 16;
            e = bi == 0 ? 1'b0 : bi <= 8 ? b[bi-1] : 1'b1;
            chk($sformatf("tx%0d_%02h_k%0d", w, b, k), w == 1 ? tx1 : tx2, e);
            if (k == lim / 2) chk($sformatf("busy%0d_mid_%02h", w, b), w == 1 ? busy1 : busy2, 1);
        end
    endtask
    always @(negedge clk) begin
        int j;
        if (rx_en) begin
            if (!rx_on) begin
                if (prev && !tx1) begin
                    rx_on = 1;
                    rx_t = 0;
                end
            end else rx_t++;
            if (rx_on && rx_t % 16 == 8) begin
                j = rx_t / 16;
                if (j == 0 && tx1) rx_on = 0;
                else if (j >= 1 && j <= 8) rx_b[j-1] = tx1;
                else if (j == 9) begin
                    if (tx1) rxq.push_back(rx_b);
                    else rx_ferr++;
                    rx_on = 0;
                end
            end
        end
        prev = tx1;
    end
    initial begin
        logic [7:0] b0, b1, b2, b3;
        logic [7:0] sent[16];
        i1.data = 0; i1.data_valid = 0; i2.data = 0; i2.data_valid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        r1 = i1.ready; r2 = i2.ready;
        chk("rst_tx", tx1, 1);
        chk("rst_ready", i1.ready, 1);
        chk("rst_busy", busy1, 0);
        chk("rst_count", cnt1, 0);
        chk("rst_tx2", tx2, 1);
        repeat (100) begin
            step();
            if (tx1 !== 1'b1 || busy1 !== 1'b0) idle_bad++;
        end
        chk("idle_100", idle_bad, 0);
        pend1 = '{8'hA5};
        step(); step();
        chk("a5_count", cnt1, 1);
        chk("a5_tx_pre", tx1, 1);
        chk("a5_busy_pre", busy1, 1);
        check_frame(1, 8'hA5, 1, 0);
        step();
        chk("a5_busy_end", busy1, 0);
        chk("a5_tx_end", tx1, 1);
        chk("a5_count_end", cnt1, 0);
        acc1.delete(); fst.delete(); full_seen = 0;
        pend1 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        step(); step();
        for (int i = 1; i <= 6; i++) check_frame(1, 8'(i), 1, 0);
        chk("bb_accepts", acc1.size(), 6);
        chk("bb_first_pop", fst[0] - acc1[0], 1);
        chk("bb_06_accept", acc1[5], fst[1] + 1);
        chk("bb_span", fst[5] - fst[0], 800);
        chk("bb_full_seen", full_seen != 0, 1);
        step();
        chk("bb_busy_end", busy1, 0);
        chk("bb_count_end", cnt1, 0);
        fst.delete();
        pend2 = '{8'hFF, 8'h00};
        step(); step();
        check_frame(2, 8'hFF, 2, 0);
        check_frame(2, 8'h00, 2, 0);
        chk("sb2_start_gap", fst[1] - fst[0], 176);
        step();
        chk("sb2_busy_end", busy2, 0);
        chk("sb2_tx_end", tx2, 1);
        b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
        pend1 = '{b0, b1, b2};
        step(); step();
        check_frame(1, b0, 1, 70);
        chk("mid_count", cnt1, 2);
        rst = 1;
        step();
        chk("mid_rst_tx", tx1, 1);
        chk("mid_rst_count", cnt1, 0);
        chk("mid_rst_busy", busy1, 0);
        chk("mid_rst_ready", i1.ready, 1);
        rst = 0;
        idle_bad = 0;
        repeat (60) begin
            step();
            if (tx1 !== 1'b1 || busy1 !== 1'b0) idle_bad++;
        end
        chk("mid_no_frames", idle_bad, 0);
        pend1 = '{b3};
        step(); step();
        check_frame(1, b3, 1, 0);
        step();
        rxq.delete();
        rx_en = 1;
        for (int i = 0; i < 16; i++) begin
            sent[i] = 8'($urandom);
            pend1.push_back(sent[i]);
        end
        for (int t = 0; t < 16 * 160 + 300 && rxq.size() < 16; t++) step();
        repeat (300) step();
        chk("loop_count", rxq.size(), 16);
        chk("loop_framing", rx_ferr, 0);
        for (int i = 0; i < 16 && i < rxq.size(); i++) chk($sformatf("loop_byte%0d", i), rxq[i], sent[i]);
        chk("ready_rule", rule_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
